mult_result_buffer: RTL and testbench
=====================================

Name: mult_result_buffer

Overview:
- Downstream consumer of the last stage of the 8-stage pipelined 64-bit multiplier.
- Captures each product when the final stage's done pulses and queues it in a small FIFO.
- Presents results to the consumer over a valid/ready handshake.
- The pipeline cannot stall, so the block also throttles issue upstream with credits: an operation may start only if a FIFO slot is guaranteed when it emerges.

Parameters:
- WIDTH, 64, product width in bits.
- DEPTH, 4, FIFO entries; also the maximum of in-flight plus buffered operations; must be >= 1.
- CW, $clog2(DEPTH+1), width of the occupancy and in-flight counters.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  reset, synchronous, active-high.
- issue_valid  input  1  upstream requests to start a multiply this cycle.
- issue_ready  output  1  a credit is available; start permitted.
- pipe_start  output  1  start to the first pipeline stage; equals issue_valid & issue_ready.
- pipe_done  input  1  done from the last pipeline stage.
- pipe_product  input  WIDTH  product_out from the last pipeline stage, valid when pipe_done=1.
- result_valid  output  1  FIFO non-empty.
- result_ready  input  1  consumer accepts the head entry.
- result_data  output  WIDTH  head entry, show-ahead.
- count  output  CW  entries currently stored.
- in_flight  output  CW  operations started but not yet done.
- err_overflow  output  1  sticky: pipe_done arrived with FIFO full and no pop.
- err_spurious  output  1  sticky: pipe_done arrived with in_flight==0.

Behaviour:
- Reset values: count=0, in_flight=0, rd_ptr=wr_ptr=0, err_overflow=0, err_spurious=0.
  - result_valid is therefore 0. result_data is don't-care while result_valid=0.
  - issue_ready is forced 0 while reset=1, so pipe_start=0 during reset.
- issue_ready = !reset && (in_flight + count < DEPTH).
  - Computed from registered state only; no combinational path from result_ready or pipe_done.
  - A pop or done in cycle N frees its credit for cycle N+1.
- start = pipe_start. push = pipe_done. pop = result_valid & result_ready.
- in_flight next value = in_flight + start - (push & in_flight!=0).
  - start and push in the same cycle leave it unchanged.
- Write rule:
  - On push with (count<DEPTH or pop): mem[wr_ptr] <= pipe_product; wr_ptr advances.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- Read rule: on pop, rd_ptr advances with wrap. result_data = mem[rd_ptr].
- count next value = count + accepted_push - pop.
  - Simultaneous push and pop when full: both happen, count stays DEPTH.
  - Simultaneous push and pop when count=1: the new entry becomes head next cycle.
- No bypass path: a push into an empty FIFO gives result_valid=1 in the following cycle. Buffer latency is 1 cycle after pipe_done.
- Overflow: push with count==DEPTH and no pop.
  - Product is dropped and err_overflow sets.
  - Unreachable while the credit rule is respected.
- Spurious done: push with in_flight==0.
  - err_spurious sets.
  - The product is still stored if space exists; in_flight does not underflow.
- Error flags clear only on reset.
- Reset mid-operation:
  - All buffered and in-flight results are discarded.
  - The pipeline's own done chain is also reset, so no stale done follows.
- Consumer holding result_ready=0 does not corrupt data; the head stays stable while result_valid=1 and not popped.

Decomposition:
- Shared package mult_pkg:
  - MULT_WIDTH=64.
  - MULT_STAGES=8.
  - typedef logic [MULT_WIDTH-1:0] mult_word_t.
- One sub-module: mult_result_fifo.
  - Contents: storage, rd/wr pointers, count, push/pop/full/empty.
  - Parameterised on WIDTH and DEPTH.
- The top holds the credit and in-flight logic and the error flags.

Test Plan:
- Single op: issue_valid pulse at cycle 0; pipe_done with product 0x0000_0000_0000_0F0F at cycle 8; result_ready=1 -> pipe_start at cycle 0; in_flight 1 for cycles 1-8; result_valid at cycle 9 with result_data=0x0F0F; count returns to 0 at cycle 10.
- Credit limit: DEPTH=4, issue_valid held high, result_ready=0 -> exactly 4 pipe_start pulses; issue_ready=0 afterwards. After 4 dones, count=4 and in_flight=0. Popping one entry gives issue_ready=1 on the next cycle.
- Back-to-back streaming: issue_valid=1 and result_ready=1 continuously, products 1,2,3,... -> results delivered in order with no gaps after the initial fill; count never exceeds 1.
- Full with simultaneous push/pop: count=4 (entries 10,20,30,40), push 50 and pop in the same cycle -> result_data=20 next cycle; count stays 4; err_overflow=0.
- Error injection: force pipe_done with in_flight=0 -> err_spurious=1. Force pipe_done with count=4 and result_ready=0 -> err_overflow=1, value dropped, FIFO contents unchanged.
- Reset mid-stream: assert reset with count=2 and in_flight=2 -> next cycle count=0, in_flight=0, result_valid=0, both error flags 0; issue_ready=0 during reset and 1 the cycle after release.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined 64-bit multiplier and its consumers.
//   MULT_WIDTH  : product width in bits
//   MULT_STAGES : number of pipeline stages from start to done
//   mult_word_t : one product word
package mult_pkg;
    localparam int MULT_WIDTH  = 64;
    localparam int MULT_STAGES = 8;

    typedef logic [MULT_WIDTH-1:0] mult_word_t;
endpackage

// File: rtl/mult_result_fifo.sv
// Small show-ahead FIFO for multiplier results.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   push, wr_data    : write request and data; dropped when full with no pop
//   pop              : read request; ignored while empty
//   rd_data          : head entry (valid while !empty)
//   count            : entries stored
//   full, empty      : occupancy flags from registered count
module mult_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot the push needs.
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/mult_result_buffer.sv
// Result buffer behind the last multiplier stage. Queues products on
// pipe_done and hands them out over valid/ready, while granting issue
// credits so every started op is guaranteed a FIFO slot on arrival.
// Ports:
//   clock, reset                  : system clock, synchronous active-high reset
//   issue_valid / issue_ready     : upstream start request / credit available
//   pipe_start                    : start to first stage (issue_valid & issue_ready)
//   pipe_done, pipe_product       : last-stage done pulse and product
//   result_valid/ready/data       : consumer handshake, show-ahead head entry
//   count, in_flight              : stored entries, started-but-not-done ops
//   err_overflow, err_spurious    : sticky error flags, cleared by reset only
module mult_result_buffer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    output logic             pipe_start,
    input  logic             pipe_done,
    input  logic [WIDTH-1:0] pipe_product,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    in_flight,
    output logic             err_overflow,
    output logic             err_spurious
);
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_spurious_q, err_spurious_d;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW:0]   credits_used;

    mult_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (pipe_done),
        .wr_data (pipe_product),
        .pop     (pop),
        .rd_data (result_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign result_valid = !empty;
    assign pop          = result_valid && result_ready;

    // Registered state only, so a pop or done frees its credit next cycle
    // and there is no combinational path from the consumer to the issuer.
    assign credits_used = {1'b0, in_flight_q} + {1'b0, count};
    assign issue_ready  = !reset && (credits_used < (CW+1)'(DEPTH));
    assign pipe_start   = issue_valid && issue_ready;

    always_comb begin
        in_flight_d    = in_flight_q + CW'(pipe_start)
                         - CW'(pipe_done && (in_flight_q != '0));
        err_overflow_d = err_overflow_q || (pipe_done && full && !pop);
        err_spurious_d = err_spurious_q || (pipe_done && (in_flight_q == '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight_q    <= '0;
            err_overflow_q <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            in_flight_q    <= in_flight_d;
            err_overflow_q <= err_overflow_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign in_flight    = in_flight_q;
    assign err_overflow = err_overflow_q;
    assign err_spurious = err_spurious_q;
endmodule

// File: tb/tb_mult_result_buffer.sv
module tb_mult_result_buffer;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int STAGES = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic             pipe_start;
    logic             pipe_done;
    logic [WIDTH-1:0] pipe_product;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic [WIDTH-1:0] result_data;
    logic [CW-1:0]    count;
    logic [CW-1:0]    in_flight;
    logic             err_overflow;
    logic             err_spurious;

    mult_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .pipe_start   (pipe_start),
        .pipe_done    (pipe_done),
        .pipe_product (pipe_product),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .count        (count),
        .in_flight    (in_flight),
        .err_overflow (err_overflow),
        .err_spurious (err_spurious)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in for the multiplier pipeline: start -> done STAGES cycles later.
    logic             st_v [STAGES];
    logic [WIDTH-1:0] st_d [STAGES];
    logic             force_done = 1'b0;
    logic [WIDTH-1:0] force_prod = '0;
    logic             start_cap = 1'b0;
    logic             rst_cap = 1'b1;
    logic [WIDTH-1:0] prod_cap = '0;
    bit               prod_mode = 1'b0;
    logic [WIDTH-1:0] prod_next = '0;
    logic [WIDTH-1:0] prod_inc = 64'd1;

    assign pipe_done    = st_v[STAGES-1] | force_done;
    assign pipe_product = force_done ? force_prod : st_d[STAGES-1];

    initial begin
        for (int i = 0; i < STAGES; i++) begin
            st_v[i] = 1'b0;
            st_d[i] = '0;
        end
    end

    always @(posedge clock) begin
        #1;
        if (rst_cap) begin
            for (int i = 0; i < STAGES; i++) st_v[i] = 1'b0;
        end else begin
            for (int i = STAGES-1; i > 0; i--) begin
                st_v[i] = st_v[i-1];
                st_d[i] = st_d[i-1];
            end
            st_v[0] = start_cap;
            st_d[0] = prod_cap;
        end
    end

    // Behavioural reference: a queue of stored products plus counters.
    logic [WIDTH-1:0] m_q[$];
    int               m_if = 0;
    bit               m_eov = 0;
    bit               m_esp = 0;
    bit               check_en = 0;

    always @(negedge clock) begin
        bit exp_ready, exp_start, exp_valid, do_pop;
        int sz;
        if (check_en) begin
            exp_ready = !reset && ((m_if + m_q.size()) < DEPTH);
            exp_start = issue_valid && exp_ready;
            exp_valid = (m_q.size() > 0);
            chk("issue_ready", issue_ready, exp_ready);
            chk("pipe_start", pipe_start, exp_start);
            chk("result_valid", result_valid, exp_valid);
            if (exp_valid) chk("result_data", result_data, m_q[0]);
            chk("count", count, m_q.size());
            chk("in_flight", in_flight, m_if);
            chk("err_overflow", err_overflow, m_eov);
            chk("err_spurious", err_spurious, m_esp);
            if (reset) begin
                m_q.delete();
                m_if  = 0;
                m_eov = 0;
                m_esp = 0;
            end else begin
                do_pop = exp_valid && result_ready;
                sz = m_q.size();
                if (pipe_done && m_if == 0) m_esp = 1;
                m_if = m_if + (exp_start ? 1 : 0) - ((pipe_done && m_if != 0) ? 1 : 0);
                if (do_pop) void'(m_q.pop_front());
                if (pipe_done) begin
                    if (sz < DEPTH || do_pop) m_q.push_back(pipe_product);
                    else m_eov = 1;
                end
            end
        end
        start_cap = pipe_start;
        rst_cap   = reset;
        if (pipe_start) begin
            if (prod_mode) begin
                prod_cap  = prod_next;
                prod_next = prod_next + prod_inc;
            end else begin
                prod_cap = {$urandom, $urandom};
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int starts;

    initial begin
        // Reset
        step();
        check_en = 1;
        step();
        step();
        @(negedge clock);
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_count", count, 0);
        step();
        reset = 1'b0;

        // Single op: start at cycle 0, done at 8, visible at 9, drained by 10.
        prod_mode = 1;
        prod_next = 64'h0000_0000_0000_0F0F;
        prod_inc  = 64'd0;
        result_ready = 1'b1;
        step();
        for (int c = 0; c <= 10; c++) begin
            issue_valid = (c == 0);
            @(negedge clock);
            if (c == 0) chk("single_start", pipe_start, 1);
            if (c == 1 || c == 8) chk("single_in_flight", in_flight, 1);
            if (c == 9) begin
                chk("single_valid", result_valid, 1);
                chk("single_data", result_data, 64'h0F0F);
                chk("single_in_flight_done", in_flight, 0);
            end
            if (c == 10) chk("single_count", count, 0);
            step();
        end

        // Credit limit
        prod_next = 64'd1;
        prod_inc  = 64'd1;
        result_ready = 1'b0;
        issue_valid  = 1'b1;
        starts = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (pipe_start) starts++;
            step();
        end
        @(negedge clock);
        chk("credit_starts", starts, 4);
        chk("credit_count", count, 4);
        chk("credit_in_flight", in_flight, 0);
        chk("credit_issue_ready", issue_ready, 0);
        step();
        result_ready = 1'b1;
        @(negedge clock);
        chk("credit_pop_same_cycle", issue_ready, 0);
        step();
        result_ready = 1'b0;
        @(negedge clock);
        chk("credit_freed", issue_ready, 1);
        step();
        issue_valid  = 1'b0;
        result_ready = 1'b1;
        for (int c = 0; c < 16; c++) step();

        // Full with simultaneous push/pop (forced done: in_flight is 0 when full)
        prod_next = 64'd10;
        prod_inc  = 64'd10;
        result_ready = 1'b0;
        issue_valid  = 1'b1;
        for (int c = 0; c < 16; c++) step();
        issue_valid = 1'b0;
        @(negedge clock);
        chk("full_count", count, 4);
        chk("full_head", result_data, 64'd10);
        step();
        force_done   = 1'b1;
        force_prod   = 64'd50;
        result_ready = 1'b1;
        step();
        force_done   = 1'b0;
        result_ready = 1'b0;
        @(negedge clock);
        chk("pushpop_data", result_data, 64'd20);
        chk("pushpop_count", count, 4);
        chk("pushpop_overflow", err_overflow, 0);
        chk("pushpop_spurious", err_spurious, 1);

        // Overflow: drop and keep contents
        step();
        force_done = 1'b1;
        force_prod = 64'd99;
        step();
        force_done = 1'b0;
        @(negedge clock);
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_count", count, 4);
        chk("ovf_head", result_data, 64'd20);
        step();
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("ovf_order", result_data, 64'(20 + 10 * i));
            step();
        end
        @(negedge clock);
        chk("ovf_flag_sticky", err_overflow, 1);

        // Clean spurious done
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        result_ready = 1'b0;
        force_done = 1'b1;
        force_prod = 64'h55;
        step();
        force_done = 1'b0;
        @(negedge clock);
        chk("spur_flag", err_spurious, 1);
        chk("spur_overflow", err_overflow, 0);
        chk("spur_count", count, 1);
        chk("spur_data", result_data, 64'h55);
        chk("spur_in_flight", in_flight, 0);
        step();
        result_ready = 1'b1;
        step();
        step();
        result_ready = 1'b0;

        // Reset mid-stream: count=2, in_flight=2 at cycle 10
        prod_next = 64'd100;
        prod_inc  = 64'd1;
        for (int c = 0; c <= 11; c++) begin
            issue_valid = (c < 4);
            reset = (c == 10);
            @(negedge clock);
            if (c == 9) begin
                chk("mid_count", count, 1);
                chk("mid_in_flight", in_flight, 3);
            end
            if (c == 10) chk("mid_reset_ready", issue_ready, 0);
            if (c == 11) begin
                chk("mid_post_count", count, 0);
                chk("mid_post_in_flight", in_flight, 0);
                chk("mid_post_valid", result_valid, 0);
                chk("mid_post_ovf", err_overflow, 0);
                chk("mid_post_spur", err_spurious, 0);
                chk("mid_post_ready", issue_ready, 1);
            end
            step();
        end

        // Back-to-back streaming
        prod_next = 64'd1;
        prod_inc  = 64'd1;
        issue_valid  = 1'b1;
        result_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            chk("stream_count_le1", (count <= 1), 1);
            step();
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 12; c++) step();

        // Randomised traffic
        prod_mode = 0;
        for (int c = 0; c < 2000; c++) begin
            issue_valid  = ($urandom_range(0, 3) != 0);
            result_ready = ($urandom_range(0, 2) != 0);
            force_done   = ($urandom_range(0, 99) == 0);
            force_prod   = {$urandom, $urandom};
            reset        = ($urandom_range(0, 299) == 0);
            step();
        end
        force_done = 1'b0;
        reset = 1'b0;
        issue_valid = 1'b0;
        result_ready = 1'b1;
        for (int c = 0; c < 16; c++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
